// File: rtl/alu_exec.sv
//==============================================================================
// Module      : alu_exec
// Description : Execute/writeback stage in front of an 8x8 register file.
//               Accepts one decoded instruction per handshake, reads the two
//               operands through the register file's single combinational
//               read port, computes an ALU result, writes it back and
//               maintains the Z/C flags. Fixed 4-cycle sequence per
//               instruction (IDLE -> RD_S -> RD_D -> WB).
// Ports       : clk_in, reset_in (async, active-low)
//               op_valid_in / op_ready_out        instruction handshake
//               op_code_in, op_rd_in, op_rs_in, op_imm_in  decoded fields
//               rf_read_addr_out / rf_read_data_in register file read port
//               rf_write_addr_out/_en_out/_data_out register file write port
//               flag_z_out, flag_c_out            status flags
//               done_out                          one-cycle retire pulse
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module alu_exec #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              op_valid_in,
  output logic              op_ready_out,
  input  logic [3:0]        op_code_in,
  input  logic [ADDR_W-1:0] op_rd_in,
  input  logic [ADDR_W-1:0] op_rs_in,
  input  logic [DATA_W-1:0] op_imm_in,
  output logic [ADDR_W-1:0] rf_read_addr_out,
  input  logic [DATA_W-1:0] rf_read_data_in,
  output logic [ADDR_W-1:0] rf_write_addr_out,
  output logic              rf_write_en_out,
  output logic [DATA_W-1:0] rf_write_data_out,
  output logic              flag_z_out,
  output logic              flag_c_out,
  output logic              done_out
);

  localparam logic [3:0] c_OP_MOV  = 4'd0;
  localparam logic [3:0] c_OP_LDI  = 4'd1;
  localparam logic [3:0] c_OP_ADD  = 4'd2;
  localparam logic [3:0] c_OP_SUB  = 4'd3;
  localparam logic [3:0] c_OP_AND  = 4'd4;
  localparam logic [3:0] c_OP_OR   = 4'd5;
  localparam logic [3:0] c_OP_XOR  = 4'd6;
  localparam logic [3:0] c_OP_ADC  = 4'd7;
  localparam logic [3:0] c_OP_SBC  = 4'd8;
  localparam logic [3:0] c_OP_SHL  = 4'd9;
  localparam logic [3:0] c_OP_SHR  = 4'd10;
  localparam logic [3:0] c_OP_CMP  = 4'd11;
  localparam logic [3:0] c_OP_ADDI = 4'd12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD_S = 2'd1,
    S_RD_D = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Latched instruction fields
  logic [3:0]        r_code;
  logic [ADDR_W-1:0] r_rd;
  logic [ADDR_W-1:0] r_rs;
  logic [DATA_W-1:0] r_imm;

  // Operand B (captured in RD_S)
  logic [DATA_W-1:0] r_b;

  // Result staged at the RD_D edge and presented during WB
  logic              r_wr_op;
  logic              r_nz;
  logic              r_nc;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;

  logic              r_flag_z;
  logic              r_flag_c;

  // ALU signals
  logic [DATA_W-1:0] w_a;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W-1:0] w_res;
  logic              w_wr;
  logic              w_keep_z;
  logic              w_z;
  logic              w_c;
  logic [DATA_W:0]   w_cin_ext;

  //--------------------------------------------------------------------------
  // State register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  //--------------------------------------------------------------------------
  // Next-state logic
  //--------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (op_valid_in) w_state_nxt = S_RD_S;
      S_RD_S:  w_state_nxt = S_RD_D;
      S_RD_D:  w_state_nxt = S_WB;
      S_WB:    w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  //--------------------------------------------------------------------------
  // ALU. Operand A is taken straight from the read port during RD_D, so the
  // complete result and the next flag values are ready at the RD_D edge and
  // can be registered; WB then drives only flops onto the write port.
  //--------------------------------------------------------------------------
  assign w_a       = rf_read_data_in;
  assign w_cin_ext = {{DATA_W{1'b0}}, r_flag_c};

  always_comb begin
    w_sum    = '0;
    w_res    = r_b;
    w_wr     = 1'b1;
    w_keep_z = 1'b0;
    w_c      = r_flag_c;
    case (r_code)
      c_OP_MOV: w_res = r_b;
      c_OP_LDI: w_res = r_imm;
      c_OP_ADD: begin
        w_sum = {1'b0, w_a} + {1'b0, r_b};
        w_res = w_sum[DATA_W-1:0];
        w_c   = w_sum[DATA_W];
      end
      // 9-bit subtraction: bit DATA_W is set exactly when a borrow occurs
      c_OP_SUB, c_OP_CMP: begin
        w_sum = {1'b0, w_a} - {1'b0, r_b};
        w_res = w_sum[DATA_W-1:0];
        w_c   = w_sum[DATA_W];
        w_wr  = (r_code == c_OP_SUB);
      end
      c_OP_AND: begin w_res = w_a & r_b; w_c = 1'b0; end
      c_OP_OR:  begin w_res = w_a | r_b; w_c = 1'b0; end
      c_OP_XOR: begin w_res = w_a ^ r_b; w_c = 1'b0; end
      c_OP_ADC: begin
        w_sum = {1'b0, w_a} + {1'b0, r_b} + w_cin_ext;
        w_res = w_sum[DATA_W-1:0];
        w_c   = w_sum[DATA_W];
      end
      c_OP_SBC: begin
        w_sum = {1'b0, w_a} - {1'b0, r_b} - w_cin_ext;
        w_res = w_sum[DATA_W-1:0];
        w_c   = w_sum[DATA_W];
      end
      c_OP_SHL: begin
        w_res = {w_a[DATA_W-2:0], 1'b0};
        w_c   = w_a[DATA_W-1];
      end
      c_OP_SHR: begin
        w_res = {1'b0, w_a[DATA_W-1:1]};
        w_c   = w_a[0];
      end
      c_OP_ADDI: begin
        w_sum = {1'b0, w_a} + {1'b0, r_imm};
        w_res = w_sum[DATA_W-1:0];
        w_c   = w_sum[DATA_W];
      end
      default: begin
        // NOP: no write, both flags retained
        w_wr     = 1'b0;
        w_keep_z = 1'b1;
      end
    endcase
    w_z = w_keep_z ? r_flag_z : (w_res == '0);
  end

  //--------------------------------------------------------------------------
  // Datapath registers
  //--------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_code    <= '0;
      r_rd      <= '0;
      r_rs      <= '0;
      r_imm     <= '0;
      r_b       <= '0;
      r_wr_op   <= 1'b0;
      r_nz      <= 1'b0;
      r_nc      <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_flag_z  <= 1'b0;
      r_flag_c  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (op_valid_in) begin
            r_code <= op_code_in;
            r_rd   <= op_rd_in;
            r_rs   <= op_rs_in;
            r_imm  <= op_imm_in;
          end
        end
        S_RD_S: r_b <= rf_read_data_in;
        S_RD_D: begin
          r_wr_op <= w_wr;
          r_nz    <= w_z;
          r_nc    <= w_c;
          // Non-writing ops leave the write port address/data untouched
          if (w_wr) begin
            r_wr_addr <= r_rd;
            r_wr_data <= w_res;
          end
        end
        S_WB: begin
          r_flag_z <= r_nz;
          r_flag_c <= r_nc;
        end
        default: ;
      endcase
    end
  end

  //--------------------------------------------------------------------------
  // Outputs: strobes decode only registered state, so they cannot glitch
  //--------------------------------------------------------------------------
  assign op_ready_out      = (r_state == S_IDLE);
  assign done_out          = (r_state == S_WB);
  assign rf_write_en_out   = (r_state == S_WB) && r_wr_op;
  assign rf_write_addr_out = r_wr_addr;
  assign rf_write_data_out = r_wr_data;
  assign flag_z_out        = r_flag_z;
  assign flag_c_out        = r_flag_c;

  always_comb begin
    rf_read_addr_out = '0;
    if (r_state == S_RD_S) rf_read_addr_out = r_rs;
    else if (r_state == S_RD_D) rf_read_addr_out = r_rd;
  end

endmodule

`default_nettype wire

// File: doc/alu_exec.md
Name: alu_exec

Overview:
Execute/writeback stage placed directly in front of the 8x8 register file.
- Accepts one decoded instruction per handshake and reads up to two operands through the register file's single combinational read port.
- Computes an 8-bit ALU result, writes it back through the file's write port and maintains Z/C flags.
- Fixed-latency multi-cycle sequencer; the fetch/decode stage sits upstream.

Parameters:
DATA_W, 8, datapath and register width
ADDR_W, 3, register index width (2**ADDR_W registers)

Ports:
clk_in  input  1  clock, all state updates on rising edge
reset_in  input  1  asynchronous, active-low reset
op_valid_in  input  1  instruction fields valid
op_ready_out  output  1  block can accept an instruction (high only in IDLE)
op_code_in  input  4  operation code
op_rd_in  input  ADDR_W  destination / first source register
op_rs_in  input  ADDR_W  second source register
op_imm_in  input  DATA_W  immediate
rf_read_addr_out  output  ADDR_W  to register file read address
rf_read_data_in  input  DATA_W  from register file read data (combinational)
rf_write_addr_out  output  ADDR_W  to register file write address
rf_write_en_out  output  1  to register file write enable
rf_write_data_out  output  DATA_W  to register file write data
flag_z_out  output  1  zero flag
flag_c_out  output  1  carry/borrow flag
done_out  output  1  one-cycle pulse, instruction retired

Behaviour:
- Reset (reset_in=0, async): state IDLE. op_ready_out=1, rf_write_en_out=0, done_out=0, rf_read_addr_out=0, rf_write_addr_out=0, rf_write_data_out=0, flags Z=0 C=0, latched fields cleared.
- Reset mid-operation: the instruction is abandoned. No write occurs, done_out stays 0, flags keep their reset values.
- FSM states and sequence:
  - IDLE: ready=1. On valid&&ready at a clock edge, latch code/rd/rs/imm and go to RD_S.
  - RD_S: read_addr=rs. Capture rf_read_data_in into B at the edge. Go to RD_D.
  - RD_D: read_addr=rd. Capture rf_read_data_in into A at the edge. Go to WB.
  - WB: write_addr=rd, write_data=result, write_en=1 for writing ops, done_out=1. Flags update at the edge. Go to IDLE.
- Every opcode takes the full sequence. Accept edge at T0, WB asserted in cycle T3, register-file write at the end of T3. Next accept is possible at the T4 edge, giving one instruction per 4 cycles.
- rf_read_addr_out=0 outside RD_S/RD_D. write_en and done_out are decoded only from the state register and are glitch-free.
- In WB, write_addr and write_data are stable for the whole cycle. Outside WB, write_en=0 and addr/data hold their last values.
- Inputs are ignored when ready=0. Valid may stay high across instructions.
- Opcodes (A=rd value, B=rs value, all arithmetic mod 256, carry = bit 8 of the 9-bit sum):
  - 0 MOV: rd<=B. Z updated, C kept.
  - 1 LDI: rd<=imm. Z updated, C kept.
  - 2 ADD: A+B.
  - 3 SUB: A-B. C=1 when A<B (borrow).
  - 4 AND, 5 OR, 6 XOR: bitwise. C cleared.
  - 7 ADC: A+B+C.
  - 8 SBC: A-B-C. C=borrow.
  - 9 SHL: A<<1, C=A[7].
  - 10 SHR: logical A>>1, C=A[0].
  - 11 CMP: SUB flags only, no write.
  - 12 ADDI: A+imm, carry as ADD.
  - 13-15 NOP: no write, flags unchanged, done still pulses.
- Z=1 when the 8-bit result is 0, for every opcode that updates flags.
- ADC/SBC use the C value present before the instruction.
- rd==rs is legal: both reads return the same register. The write of instruction N completes before the reads of instruction N+1, so there is no hazard.

Test Plan:
- Reset then LDI r1,0x7F; LDI r2,0x01; ADD r1,r2 -> r1=0x80, Z=0, C=0. Each done pulse is 3 cycles after its accept edge and ready is low for 3 cycles.
- r1=0xFF, r2=0x01, ADD r1,r2 -> r1=0x00, Z=1, C=1. Then ADC r1,r2 -> r1=0x02, C=0.
- r3=0x10, r4=0x20, SUB r3,r4 -> r3=0xF0, C=1, Z=0. CMP r4,r4 -> no write_en, Z=1, C=0, r4 unchanged.
- SHL on 0x81 -> 0x02, C=1. SHR on 0x01 -> 0x00, Z=1, C=1. AND 0xF0&0x0F -> 0x00, Z=1, C=0. Opcode 14 -> done pulse, no write, flags unchanged.
- Hold valid high with back-to-back instructions -> accepts exactly every 4 cycles, ready=0 in RD_S/RD_D/WB, no input change is sampled in those states.
- Assert reset_in low during RD_D of ADD r5,r6 -> outputs reach reset values immediately (asynchronously), r5 is not written, no done pulse, ready=1 after release.
